// File: rtl/rom_arbiter_pkg.sv
// Shared constants and types for the instruction-ROM arbiter.
package rom_arbiter_pkg;

   // Arbitration modes selectable through the ARB_MODE parameter
   localparam int ARB_RR    = 0;
   localparam int ARB_FIX_D = 1;

   // Port encodings used for the last-grant pointer
   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   // Slot state: idle, or a response outstanding for one of the two ports
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND_I = 2'd1,
      ST_PEND_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rom_arbiter_arb.sv
// Two-input arbiter: round-robin via a last-grant pointer, or fixed D-over-I.
module rr_arb2
   import rom_arbiter_pkg::*;
(
   input  logic CLK,
   input  logic RSTn,
   input  logic mode,
   input  logic en,
   input  logic req_i,
   input  logic req_d,
   output logic gnt_i,
   output logic gnt_d
);

   logic last;

   // Pick a winner when the slot is free; ties resolved by mode and last grant
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (en) begin
         if (req_i && !req_d) begin
            gnt_i = 1'b1;
         end else if (req_d && !req_i) begin
            gnt_d = 1'b1;
         end else if (req_i && req_d) begin
            if (mode) begin
               gnt_d = 1'b1;
            end else if (last == PORT_D) begin
               gnt_i = 1'b1;
            end else begin
               gnt_d = 1'b1;
            end
         end
      end
   end

   // Remember the last granted port; reset points at D so I wins the first tie
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         last <= PORT_D;
      end else if (gnt_i) begin
         last <= PORT_I;
      end else if (gnt_d) begin
         last <= PORT_D;
      end
   end

endmodule

// File: rtl/rom_arbiter.sv
// Shares a single-port synchronous ROM between the fetch (I) and data (D) ports.
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int ARB_MODE = 0,
   parameter int AW       = 32,
   parameter int DW       = 32
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          IREQ,
   input  logic [AW-1:0] IADDR,
   output logic          IGNT,
   output logic          IRVALID,
   output logic [DW-1:0] IRDATA,
   input  logic          IRREADY,
   input  logic          DREQ,
   input  logic [AW-1:0] DADDR,
   output logic          DGNT,
   output logic          DRVALID,
   output logic [DW-1:0] DRDATA,
   input  logic          DRREADY,
   output logic          ROM_EN,
   output logic [AW-1:0] ROM_ADDR,
   input  logic [DW-1:0] ROM_DOUT
);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       owner_done;
   logic       slot_free;
   logic       gnt_i;
   logic       gnt_d;

   // Responses come straight from the held ROM output of the owning port
   assign IRVALID = RSTn && (state == ST_PEND_I);
   assign DRVALID = RSTn && (state == ST_PEND_D);
   assign IRDATA  = ROM_DOUT;
   assign DRDATA  = ROM_DOUT;

   // The slot frees up when idle or when the owner takes its response this cycle
   always_comb begin
      owner_done = 1'b0;
      case (state)
         ST_PEND_I: owner_done = IRVALID && IRREADY;
         ST_PEND_D: owner_done = DRVALID && DRREADY;
         default:   owner_done = 1'b0;
      endcase
      slot_free = (state == ST_IDLE) || owner_done;
   end

   rr_arb2 u_arb (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .mode  (ARB_MODE == ARB_FIX_D),
      .en    (slot_free && RSTn),
      .req_i (IREQ),
      .req_d (DREQ),
      .gnt_i (gnt_i),
      .gnt_d (gnt_d)
   );

   assign IGNT     = gnt_i;
   assign DGNT     = gnt_d;
   assign ROM_EN   = gnt_i || gnt_d;
   assign ROM_ADDR = gnt_d ? DADDR : IADDR;

   // A new grant takes the slot even as the old owner completes
   always_comb begin
      state_nxt = state;
      if (gnt_i) begin
         state_nxt = ST_PEND_I;
      end else if (gnt_d) begin
         state_nxt = ST_PEND_D;
      end else if (owner_done) begin
         state_nxt = ST_IDLE;
      end
   end

   // Slot state register; reset silently drops any outstanding response
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   a_one_grant : assert property (@(posedge CLK) disable iff (!RSTn) !(IGNT && DGNT));
   a_no_overrun : assert property (@(posedge CLK) disable iff (!RSTn) ROM_EN |-> slot_free);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter in round-robin and fixed modes.
module tb_rom_arbiter;

   logic        CLK = 1'b0;

   logic        aRSTn, aIREQ, aIGNT, aIRVALID, aIRREADY;
   logic        aDREQ, aDGNT, aDRVALID, aDRREADY, aROM_EN;
   logic [31:0] aIADDR, aIRDATA, aDADDR, aDRDATA, aROM_ADDR, aROM_DOUT;

   logic        bRSTn, bIREQ, bIGNT, bIRVALID, bIRREADY;
   logic        bDREQ, bDGNT, bDRVALID, bDRREADY, bROM_EN;
   logic [31:0] bIADDR, bIRDATA, bDADDR, bDRDATA, bROM_ADDR, bROM_DOUT;

   logic [31:0] romMem [0:255];

   int passCount  = 0;
   int checkCount = 0;

   // Free-running clock
   always #5 CLK = ~CLK;

   rom_arbiter #(.ARB_MODE(0), .AW(32), .DW(32)) dutRr (
      .CLK(CLK), .RSTn(aRSTn),
      .IREQ(aIREQ), .IADDR(aIADDR), .IGNT(aIGNT), .IRVALID(aIRVALID),
      .IRDATA(aIRDATA), .IRREADY(aIRREADY),
      .DREQ(aDREQ), .DADDR(aDADDR), .DGNT(aDGNT), .DRVALID(aDRVALID),
      .DRDATA(aDRDATA), .DRREADY(aDRREADY),
      .ROM_EN(aROM_EN), .ROM_ADDR(aROM_ADDR), .ROM_DOUT(aROM_DOUT)
   );

   rom_arbiter #(.ARB_MODE(1), .AW(32), .DW(32)) dutFix (
      .CLK(CLK), .RSTn(bRSTn),
      .IREQ(bIREQ), .IADDR(bIADDR), .IGNT(bIGNT), .IRVALID(bIRVALID),
      .IRDATA(bIRDATA), .IRREADY(bIRREADY),
      .DREQ(bDREQ), .DADDR(bDADDR), .DGNT(bDGNT), .DRVALID(bDRVALID),
      .DRDATA(bDRDATA), .DRREADY(bDRREADY),
      .ROM_EN(bROM_EN), .ROM_ADDR(bROM_ADDR), .ROM_DOUT(bROM_DOUT)
   );

   // Synchronous-read ROM models with a registered address, one per DUT
   always @(posedge CLK) begin
      if (aROM_EN) aROM_DOUT <= romMem[aROM_ADDR[9:2]];
      if (bROM_EN) bROM_DOUT <= romMem[bROM_ADDR[9:2]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Drive one cycle of inputs just after the edge, then settle to the falling edge
   task automatic applyStimulus(input bit useFix, input logic rstn,
                                input logic ireq, input logic [31:0] iaddr,
                                input logic irready, input logic dreq,
                                input logic [31:0] daddr, input logic drready);
      @(posedge CLK);
      #1;
      if (useFix) begin
         bRSTn = rstn; bIREQ = ireq; bIADDR = iaddr; bIRREADY = irready;
         bDREQ = dreq; bDADDR = daddr; bDRREADY = drready;
      end else begin
         aRSTn = rstn; aIREQ = ireq; aIADDR = iaddr; aIRREADY = irready;
         aDREQ = dreq; aDADDR = daddr; aDRREADY = drready;
      end
      @(negedge CLK);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) romMem[i] = 32'hA000_0000 | i;
      romMem[0] = 32'h4000_0113;
      romMem[1] = 32'hfe01_0113;
      romMem[2] = 32'h0081_2e23;

      aRSTn = 1'b0; aIREQ = 1'b0; aIADDR = '0; aIRREADY = 1'b1;
      aDREQ = 1'b0; aDADDR = '0; aDRREADY = 1'b1;
      bRSTn = 1'b0; bIREQ = 1'b0; bIADDR = '0; bIRREADY = 1'b1;
      bDREQ = 1'b0; bDADDR = '0; bDRREADY = 1'b1;

      // Reset holds grants and responses low even with a request present
      applyStimulus(0, 0, 1, 32'h0, 1, 0, 32'h0, 1);
      checkOutput("rst_ignt", aIGNT, 0);
      checkOutput("rst_romen", aROM_EN, 0);
      checkOutput("rst_irvalid", aIRVALID, 0);
      applyStimulus(0, 0, 0, 32'h0, 1, 0, 32'h0, 1);

      // Single fetch from address 0
      applyStimulus(0, 1, 1, 32'h0, 1, 0, 32'h0, 1);
      checkOutput("f1_ignt", aIGNT, 1);
      checkOutput("f1_romen", aROM_EN, 1);
      checkOutput("f1_romaddr", aROM_ADDR, 32'h0);
      checkOutput("f1_drvalid", aDRVALID, 0);
      applyStimulus(0, 1, 0, 32'h0, 1, 0, 32'h0, 1);
      checkOutput("f2_irvalid", aIRVALID, 1);
      checkOutput("f2_irdata", aIRDATA, 32'h4000_0113);
      checkOutput("f2_drvalid", aDRVALID, 0);
      applyStimulus(0, 1, 0, 32'h0, 1, 0, 32'h0, 1);
      checkOutput("f3_irvalid", aIRVALID, 0);

      // Round-robin: fresh reset so I wins the first tie, then strict alternation
      applyStimulus(0, 0, 0, 32'h0, 1, 0, 32'h0, 1);
      applyStimulus(0, 1, 1, 32'h4, 1, 1, 32'h8, 1);
      checkOutput("rr1_ignt", aIGNT, 1);
      checkOutput("rr1_dgnt", aDGNT, 0);
      checkOutput("rr1_romaddr", aROM_ADDR, 32'h4);
      applyStimulus(0, 1, 1, 32'h4, 1, 1, 32'h8, 1);
      checkOutput("rr2_dgnt", aDGNT, 1);
      checkOutput("rr2_ignt", aIGNT, 0);
      checkOutput("rr2_romaddr", aROM_ADDR, 32'h8);
      checkOutput("rr2_irdata", aIRDATA, 32'hfe01_0113);
      checkOutput("rr2_irvalid", aIRVALID, 1);
      applyStimulus(0, 1, 1, 32'h4, 1, 1, 32'h8, 1);
      checkOutput("rr3_ignt", aIGNT, 1);
      checkOutput("rr3_drvalid", aDRVALID, 1);
      checkOutput("rr3_drdata", aDRDATA, 32'h0081_2e23);
      applyStimulus(0, 1, 1, 32'h4, 1, 1, 32'h8, 1);
      checkOutput("rr4_dgnt", aDGNT, 1);
      checkOutput("rr4_irdata", aIRDATA, 32'hfe01_0113);
      applyStimulus(0, 1, 0, 32'h4, 1, 0, 32'h8, 1);
      checkOutput("rr5_drdata", aDRDATA, 32'h0081_2e23);
      checkOutput("rr5_romen", aROM_EN, 0);

      // Backpressure on D blocks the waiting fetch until DRREADY rises
      applyStimulus(0, 1, 0, 32'h0, 1, 1, 32'h8, 0);
      checkOutput("bp0_dgnt", aDGNT, 1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 1, 32'h0, 1, 0, 32'h8, 0);
         checkOutput("bp_drvalid", aDRVALID, 1);
         checkOutput("bp_drdata", aDRDATA, 32'h0081_2e23);
         checkOutput("bp_romen", aROM_EN, 0);
         checkOutput("bp_ignt", aIGNT, 0);
      end
      applyStimulus(0, 1, 1, 32'h0, 1, 0, 32'h8, 1);
      checkOutput("bp4_ignt", aIGNT, 1);
      checkOutput("bp4_romen", aROM_EN, 1);
      checkOutput("bp4_drvalid", aDRVALID, 1);
      applyStimulus(0, 1, 0, 32'h0, 1, 0, 32'h8, 1);
      checkOutput("bp5_irvalid", aIRVALID, 1);
      checkOutput("bp5_irdata", aIRDATA, 32'h4000_0113);
      checkOutput("bp5_drvalid", aDRVALID, 0);

      // Reset with a response stalled: it is dropped and I wins the next tie
      applyStimulus(0, 1, 1, 32'h4, 0, 0, 32'h0, 1);
      checkOutput("mr0_ignt", aIGNT, 1);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(0, 0, 1, 32'h4, 0, 1, 32'h0, 1);
         checkOutput("mr_irvalid", aIRVALID, 0);
         checkOutput("mr_drvalid", aDRVALID, 0);
         checkOutput("mr_ignt", aIGNT, 0);
         checkOutput("mr_dgnt", aDGNT, 0);
         checkOutput("mr_romen", aROM_EN, 0);
      end
      applyStimulus(0, 1, 1, 32'hC, 1, 1, 32'h10, 1);
      checkOutput("mr3_ignt", aIGNT, 1);
      checkOutput("mr3_dgnt", aDGNT, 0);
      checkOutput("mr3_irvalid", aIRVALID, 0);
      applyStimulus(0, 1, 0, 32'hC, 1, 1, 32'h10, 1);
      checkOutput("mr4_dgnt", aDGNT, 1);
      checkOutput("mr4_irdata", aIRDATA, 32'hA000_0003);
      applyStimulus(0, 1, 0, 32'hC, 1, 0, 32'h10, 1);
      checkOutput("mr5_drdata", aDRDATA, 32'hA000_0004);
      checkOutput("mr5_drvalid", aDRVALID, 1);

      // A fetch request withdrawn while D holds the slot leaves no trace
      applyStimulus(0, 1, 0, 32'h0, 1, 1, 32'h8, 0);
      checkOutput("wd0_dgnt", aDGNT, 1);
      applyStimulus(0, 1, 1, 32'h14, 1, 0, 32'h8, 0);
      checkOutput("wd1_ignt", aIGNT, 0);
      checkOutput("wd1_drvalid", aDRVALID, 1);
      applyStimulus(0, 1, 0, 32'h14, 1, 0, 32'h8, 0);
      checkOutput("wd2_ignt", aIGNT, 0);
      applyStimulus(0, 1, 0, 32'h14, 1, 0, 32'h8, 1);
      checkOutput("wd3_ignt", aIGNT, 0);
      checkOutput("wd3_drvalid", aDRVALID, 1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 0, 32'h14, 1, 0, 32'h8, 1);
         checkOutput("wd_irvalid", aIRVALID, 0);
         checkOutput("wd_drvalid", aDRVALID, 0);
      end

      // Fixed priority: D wins every tie, I gets in the cycle DREQ drops
      applyStimulus(1, 0, 0, 32'h4, 1, 0, 32'h8, 1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 1, 1, 32'h4, 1, 1, 32'h8, 1);
         checkOutput("fx_dgnt", bDGNT, 1);
         checkOutput("fx_ignt", bIGNT, 0);
         if (k > 0) checkOutput("fx_drdata", bDRDATA, 32'h0081_2e23);
      end
      applyStimulus(1, 1, 1, 32'h4, 1, 0, 32'h8, 1);
      checkOutput("fx5_ignt", bIGNT, 1);
      checkOutput("fx5_dgnt", bDGNT, 0);
      checkOutput("fx5_drvalid", bDRVALID, 1);
      applyStimulus(1, 1, 0, 32'h4, 1, 0, 32'h8, 1);
      checkOutput("fx6_irvalid", bIRVALID, 1);
      checkOutput("fx6_irdata", bIRDATA, 32'hfe01_0113);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
